// File: rtl/text_term_pkg.sv
// Shared constants and state type for the text-mode VRAM character writer.
`timescale 1ns/1ps
package text_term_pkg;

  localparam int unsigned DEF_COLS   = 80;
  localparam int unsigned DEF_ROWS   = 30;
  localparam int unsigned DEF_ADDR_W = 12;

  localparam logic [7:0] CHAR_SPACE = 8'h20;
  localparam logic [7:0] CH_CR      = 8'h0D;
  localparam logic [7:0] CH_LF      = 8'h0A;
  localparam logic [7:0] CH_BS      = 8'h08;
  localparam logic [7:0] CH_FF      = 8'h0C;

  typedef enum logic [1:0] {
    CLR_ALL,
    IDLE,
    SCROLL,
    CLR_ROW
  } state_t;

endpackage

// File: rtl/text_term_writer.sv
// Character-stream writer for the text-mode VRAM: places printable bytes at a
// hardware cursor, interprets CR/LF/BS/FF and scrolls the screen up one row.
`timescale 1ns/1ps
module text_term_writer
  import text_term_pkg::*;
#(
  parameter int unsigned COLS   = DEF_COLS,
  parameter int unsigned ROWS   = DEF_ROWS,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              axi_aclk,
  input  logic              axi_aresetn,
  input  logic [7:0]        in_char,
  input  logic              in_invert,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] vram_waddr,
  output logic [7:0]        vram_wdata,
  output logic              vram_we,
  output logic [ADDR_W-1:0] vram_raddr,
  input  logic [7:0]        vram_rdata,
  output logic [6:0]        cursor_col,
  output logic [4:0]        cursor_row,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS * ROWS - 1);
  localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);
  localparam logic [6:0]        LAST_COL  = 7'(COLS - 1);
  localparam logic [4:0]        LAST_ROW  = 5'(ROWS - 1);

  state_t            state;
  state_t            next_state;
  logic [ADDR_W-1:0] cnt;
  logic              rd_active;
  logic              rd_valid;

  logic              accept;
  logic [6:0]        code;
  logic              is_print;
  logic              is_cr;
  logic              is_lf;
  logic              is_bs;
  logic              is_ff;
  logic              start_scroll;
  logic              clr_done;
  logic [ADDR_W-1:0] cell_addr;

  // bit7 of the incoming byte carries no meaning for the writer
  logic unused_bit7;
  assign unused_bit7 = in_char[7];

  // Decode the offered byte and the cursor-dependent conditions.
  always_comb begin
    accept       = in_valid && (state == IDLE);
    code         = in_char[6:0];
    is_print     = (code >= 7'h20) && (code <= 7'h7E);
    is_cr        = (code == CH_CR[6:0]);
    is_lf        = (code == CH_LF[6:0]);
    is_bs        = (code == CH_BS[6:0]);
    is_ff        = (code == CH_FF[6:0]);
    start_scroll = accept && (cursor_row == LAST_ROW) &&
                   ((is_print && (cursor_col == LAST_COL)) || is_lf);
    // Clears finish one cycle after the last-cell write is on the outputs.
    clr_done     = vram_we && (vram_waddr == LAST_ADDR);
    cell_addr    = ADDR_W'(cursor_row) * COLS_A + ADDR_W'(cursor_col);
  end

  // State register.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) state <= CLR_ALL;
    else              state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      CLR_ALL, CLR_ROW: if (clr_done) next_state = IDLE;
      IDLE: begin
        if (accept && is_ff)  next_state = CLR_ALL;
        else if (start_scroll) next_state = SCROLL;
      end
      // Leave once the final read has been drained into a write.
      SCROLL: if (rd_valid && !rd_active) next_state = CLR_ROW;
      default: next_state = CLR_ALL;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    in_ready = (state == IDLE);
    busy     = (state != IDLE);
  end

  // Registered VRAM port, cursor and the shared clear/scroll address counter.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      cursor_col <= '0;
      cursor_row <= '0;
      vram_we    <= 1'b0;
      vram_waddr <= '0;
      vram_wdata <= '0;
      vram_raddr <= '0;
      cnt        <= '0;
      rd_active  <= 1'b0;
      rd_valid   <= 1'b0;
    end else begin
      vram_we  <= 1'b0;
      rd_valid <= 1'b0;
      case (state)
        CLR_ALL, CLR_ROW: begin
          if (!clr_done) begin
            vram_we    <= 1'b1;
            vram_waddr <= cnt;
            vram_wdata <= CHAR_SPACE;
            cnt        <= cnt + ADDR_W'(1);
          end
        end
        IDLE: begin
          if (accept) begin
            if (is_print) begin
              vram_we    <= 1'b1;
              vram_waddr <= cell_addr;
              vram_wdata <= {in_invert, code};
              if (cursor_col != LAST_COL) begin
                cursor_col <= cursor_col + 7'd1;
              end else begin
                cursor_col <= '0;
                if (cursor_row != LAST_ROW) cursor_row <= cursor_row + 5'd1;
              end
            end else if (is_cr) begin
              cursor_col <= '0;
            end else if (is_lf) begin
              cursor_col <= '0;
              if (cursor_row != LAST_ROW) cursor_row <= cursor_row + 5'd1;
            end else if (is_bs) begin
              if (cursor_col != '0) cursor_col <= cursor_col - 7'd1;
            end else if (is_ff) begin
              cursor_col <= '0;
              cursor_row <= '0;
              cnt        <= '0;
            end
            if (start_scroll) begin
              vram_raddr <= COLS_A;
              rd_active  <= 1'b1;
              cnt        <= '0;
            end
          end
        end
        SCROLL: begin
          // Read address leads the write address by the RAM latency plus the
          // output register, so the write side trails reads by two cycles.
          rd_valid <= rd_active;
          if (rd_active) begin
            if (vram_raddr == LAST_ADDR) rd_active  <= 1'b0;
            else                         vram_raddr <= vram_raddr + ADDR_W'(1);
          end
          if (rd_valid) begin
            vram_we    <= 1'b1;
            vram_waddr <= cnt;
            vram_wdata <= vram_rdata;
            cnt        <= cnt + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_text_term_writer.sv
// Self-checking bench for text_term_writer with a screen-level reference model.
`timescale 1ns/1ps
module tb_text_term_writer;

  localparam int COLS  = 80;
  localparam int ROWS  = 30;
  localparam int NCELL = COLS * ROWS;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_char = '0;
  logic        in_invert = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] vram_waddr;
  logic [7:0]  vram_wdata;
  logic        vram_we;
  logic [11:0] vram_raddr;
  logic [7:0]  vram_rdata;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic        busy;

  always #5 clk = ~clk;

  text_term_writer #(.COLS(80), .ROWS(30), .ADDR_W(12)) dut (
    .axi_aclk    (clk),
    .axi_aresetn (rst_n),
    .in_char     (in_char),
    .in_invert   (in_invert),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .vram_waddr  (vram_waddr),
    .vram_wdata  (vram_wdata),
    .vram_we     (vram_we),
    .vram_raddr  (vram_raddr),
    .vram_rdata  (vram_rdata),
    .cursor_col  (cursor_col),
    .cursor_row  (cursor_row),
    .busy        (busy)
  );

  // VRAM: synchronous write, one-cycle registered read.
  logic [7:0] mem     [0:4095];
  logic [7:0] pre_img [0:NCELL-1];
  logic       preload_req = 1'b0;

  always @(posedge clk) begin
    if (preload_req) begin
      for (int i = 0; i < NCELL; i++) mem[i] <= pre_img[i];
    end else if (vram_we) begin
      mem[vram_waddr] <= vram_wdata;
    end
    vram_rdata <= mem[vram_raddr];
  end

  // Reference model: the expected screen image and cursor.
  logic [7:0] scr  [0:NCELL-1];
  logic [7:0] snap [0:NCELL-1];
  int exp_col, exp_row;
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit printable(input logic [7:0] ch);
    logic [6:0] c;
    c = ch[6:0];
    return (c >= 7'h20) && (c <= 7'h7E);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NCELL; i++) scr[i] = 8'h20;
    exp_col = 0;
    exp_row = 0;
  endfunction

  function automatic void model_scroll();
    for (int i = 0; i < NCELL - COLS; i++) scr[i] = scr[i + COLS];
    for (int i = NCELL - COLS; i < NCELL; i++) scr[i] = 8'h20;
  endfunction

  // Applies one byte; returns 1 when the writer becomes busy afterwards.
  function automatic bit model_apply(input logic [7:0] ch, input logic inv);
    logic [6:0] c;
    c = ch[6:0];
    if (printable(ch)) begin
      scr[exp_row * COLS + exp_col] = {inv, c};
      if (exp_col < COLS - 1) exp_col++;
      else begin
        exp_col = 0;
        if (exp_row < ROWS - 1) exp_row++;
        else begin model_scroll(); return 1'b1; end
      end
    end else if (c == 7'h0D) begin
      exp_col = 0;
    end else if (c == 7'h0A) begin
      exp_col = 0;
      if (exp_row < ROWS - 1) exp_row++;
      else begin model_scroll(); return 1'b1; end
    end else if (c == 7'h08) begin
      if (exp_col > 0) exp_col--;
    end else if (c == 7'h0C) begin
      model_reset();
      return 1'b1;
    end
    return 1'b0;
  endfunction

  // Called at a negedge; returns at the negedge after acceptance with valid dropped.
  task automatic send_byte(input logic [7:0] ch, input logic inv, output int waited);
    int  e_addr;
    bit  pr;
    bit  went_busy;
    waited = 0;
    while (!in_ready && waited < 6000) begin
      in_valid = 1'b0;
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check_eq("ready_timeout", in_ready, 1);
      in_valid = 1'b0;
      return;
    end
    pr     = printable(ch);
    e_addr = exp_row * COLS + exp_col;
    in_char   = ch;
    in_invert = inv;
    in_valid  = 1'b1;
    @(posedge clk);
    went_busy = model_apply(ch, inv);
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("we", vram_we, pr);
    if (pr) begin
      check_eq("waddr", vram_waddr, e_addr);
      check_eq("wdata", vram_wdata, {inv, ch[6:0]});
    end
    check_eq("col", cursor_col, exp_col);
    check_eq("row", cursor_row, exp_row);
    check_eq("ready", in_ready, !went_busy);
  endtask

  // Called at the first busy negedge of a full clear.
  task automatic check_clear(input string tag);
    int nbusy = 0;
    int nw = 0;
    int bad = 0;
    while (!in_ready && nbusy < 3000) begin
      if (vram_we) begin
        if (vram_waddr != 12'(nw) || vram_wdata != 8'h20) bad++;
        nw++;
      end
      nbusy++;
      @(negedge clk);
    end
    check_eq({tag, "_busy_cycles"}, nbusy, 2401);
    check_eq({tag, "_writes"}, nw, 2400);
    check_eq({tag, "_bad_writes"}, bad, 0);
    check_eq({tag, "_col"}, cursor_col, 0);
    check_eq({tag, "_row"}, cursor_row, 0);
  endtask

  task automatic check_screen(input string tag);
    int n = 0;
    int bad = 0;
    while (!in_ready && n < 6000) begin @(negedge clk); n++; end
    check_eq({tag, "_idle"}, in_ready, 1);
    repeat (3) @(negedge clk);
    for (int i = 0; i < NCELL; i++) if (mem[i] !== scr[i]) bad++;
    check_eq({tag, "_cells"}, bad, 0);
  endtask

  function automatic logic [7:0] rand_byte();
    int unsigned r;
    logic [7:0] ch;
    r = $urandom_range(0, 99);
    if (r < 70)      ch = 8'($urandom_range(32, 126));
    else if (r < 80) ch = 8'h0A;
    else if (r < 85) ch = 8'h0D;
    else if (r < 92) ch = 8'h08;
    else if (r < 95) ch = 8'h7F;
    else begin
      do ch = 8'($urandom_range(0, 31));
      while (ch == 8'h0A || ch == 8'h0D || ch == 8'h08 || ch == 8'h0C);
    end
    ch[7] = 1'($urandom_range(0, 1));
    return ch;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int w_tot;
    int k;
    int bad;
    logic [7:0] ch;

    // Power-up clear.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    check_clear("init");

    // Single inverted character.
    send_byte(8'h41, 1'b1, w);
    check_eq("a_data", vram_wdata, 8'hC1);

    // A full row back-to-back from (0,0).
    send_byte(8'h0D, 1'b0, w);
    w_tot = 0;
    for (int i = 0; i < COLS; i++) begin
      send_byte(8'($urandom_range(32, 126)), 1'($urandom_range(0, 1)), w);
      w_tot += w;
    end
    check_eq("b2b_stall", w_tot, 0);
    check_eq("b2b_col", cursor_col, 0);
    check_eq("b2b_row", cursor_row, 1);

    // Cursor controls at (5,3).
    send_byte(8'h0A, 1'b0, w);
    send_byte(8'h0A, 1'b0, w);
    for (int i = 0; i < 5; i++) send_byte(8'h2E, 1'b0, w);
    send_byte(8'h08, 1'b0, w);
    check_eq("bs_col", cursor_col, 4);
    send_byte(8'h0D, 1'b0, w);
    check_eq("cr_col", cursor_col, 0);
    send_byte(8'h08, 1'b0, w);
    check_eq("bs0_col", cursor_col, 0);
    send_byte(8'h0A, 1'b0, w);
    check_eq("lf_row", cursor_row, 4);

    // Random stream against the screen model.
    for (int i = 0; i < 250; i++) begin
      ch = rand_byte();
      send_byte(ch, 1'($urandom_range(0, 1)), w);
    end
    check_screen("rand");

    // Directed scroll from (79,29) with a random preloaded screen.
    send_byte(8'h0D, 1'b0, w);
    while (exp_row < ROWS - 1) send_byte(8'h0A, 1'b0, w);
    for (int i = 0; i < COLS - 1; i++) send_byte(8'h61, 1'b0, w);
    repeat (3) @(negedge clk);
    for (int i = 0; i < NCELL; i++) begin
      pre_img[i] = 8'($urandom);
      scr[i]     = pre_img[i];
    end
    preload_req = 1'b1;
    @(negedge clk);
    preload_req = 1'b0;
    for (int i = 0; i < NCELL; i++) snap[i] = scr[i];
    snap[NCELL-1] = 8'h5A;
    send_byte(8'h5A, 1'b0, w);
    check_eq("scr_raddr0", vram_raddr, 80);
    k = 0;
    bad = 0;
    while (!in_ready && k < 3000) begin
      @(negedge clk);
      k++;
      if (in_ready) break;
      if (k <= 2319 && vram_raddr != 12'(80 + k)) bad++;
      if (k >= 2 && k <= 2321) begin
        if (!vram_we || vram_waddr != 12'(k - 2) || vram_wdata !== snap[k - 2 + COLS]) bad++;
      end else if (k >= 2322 && k <= 2401) begin
        if (!vram_we || vram_waddr != 12'(2320 + k - 2322) || vram_wdata != 8'h20) bad++;
      end else if (vram_we) begin
        bad++;
      end
    end
    check_eq("scroll_ready_cycle", k, 2402);
    check_eq("scroll_bad_cycles", bad, 0);
    check_eq("scroll_col", cursor_col, 0);
    check_eq("scroll_row", cursor_row, 29);
    check_screen("scroll");

    // Reset in the middle of a scroll.
    send_byte(8'h0A, 1'b0, w);
    repeat (500) @(negedge clk);
    check_eq("mid_busy", busy, 1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_we", vram_we, 0);
    rst_n = 1'b1;
    model_reset();
    check_clear("rst");
    check_screen("rst");

    // Form feed.
    for (int i = 0; i < 7; i++) send_byte(8'($urandom_range(32, 126)), 1'b1, w);
    send_byte(8'h0C, 1'b0, w);
    check_clear("ff");
    check_screen("ff");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
